// File: rtl/up_axil_pkg.sv
// Shared types for the AXI4-Lite to up_* register-bus initiator.
package up_axil_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACPT = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } txn_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/up_axil_initiator_if.sv
// AXI4-Lite slave port plus up_* register-bus signals; slave = initiator side, master = CPU/bank side.
interface up_axil_initiator_if #(
  parameter int ADDRESS_WIDTH = 14
);
  logic                     s_axi_awvalid;
  logic                     s_axi_awready;
  logic [ADDRESS_WIDTH+1:0] s_axi_awaddr;
  logic                     s_axi_wvalid;
  logic                     s_axi_wready;
  logic [31:0]              s_axi_wdata;
  logic [3:0]               s_axi_wstrb;
  logic                     s_axi_bvalid;
  logic                     s_axi_bready;
  logic [1:0]               s_axi_bresp;
  logic                     s_axi_arvalid;
  logic                     s_axi_arready;
  logic [ADDRESS_WIDTH+1:0] s_axi_araddr;
  logic                     s_axi_rvalid;
  logic                     s_axi_rready;
  logic [1:0]               s_axi_rresp;
  logic [31:0]              s_axi_rdata;
  logic                     up_wreq;
  logic [ADDRESS_WIDTH-1:0] up_waddr;
  logic [31:0]              up_wdata;
  logic                     up_wack;
  logic                     up_rreq;
  logic [ADDRESS_WIDTH-1:0] up_raddr;
  logic [31:0]              up_rdata;
  logic                     up_rack;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_rready, up_wack, up_rdata, up_rack,
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    output s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rdata,
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_rready, up_wack, up_rdata, up_rack,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
    input  s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rdata,
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

endinterface

// File: rtl/up_axil_txn_fsm.sv
// Single-channel up_* transaction engine: accept, strobe, wait for ack or timeout, hold response.
//   state | meaning
//   IDLE  | waiting for a request from the AXI side
//   ACPT  | ready high one cycle, address/wdata captured
//   REQ   | up_*req strobe, ack already sampled
//   WAIT  | waiting for ack, timeout counter running
//   RESP  | response valid, held until the master takes it
module up_axil_txn_fsm
  import up_axil_pkg::*;
#(
  parameter int          ADDRESS_WIDTH  = 14,
  parameter int          TIMEOUT_CYCLES = 31,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD,
  parameter bit          IS_READ        = 1'b0
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  input  logic                     i_ack,
  input  logic [31:0]              i_rdata,
  input  logic                     i_resp_ready,
  output logic                     o_ready,
  output logic                     o_req,
  output logic [ADDRESS_WIDTH-1:0] o_addr,
  output logic [31:0]              o_data,
  output logic                     o_valid,
  output logic [1:0]               o_resp
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  txn_state_t               r_state;
  txn_state_t               w_state_nxt;
  logic [7:0]               r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_data;
  logic [1:0]               r_resp;
  logic                     w_done_ok;
  logic                     w_done_err;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_req       = 1'b0;
    o_valid     = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = ACPT;
      ACPT: begin
        o_ready     = 1'b1;
        w_state_nxt = REQ;
      end
      REQ: begin
        o_req = 1'b1;
        if (i_ack) begin
          w_done_ok   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // ack takes priority over a timeout landing in the same cycle
        if (i_ack) begin
          w_done_ok   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_done_err  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        o_valid = 1'b1;
        if (i_resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_resp <= RESP_OKAY;
    end else begin
      if (r_state == ACPT) begin
        r_cnt  <= '0;
        r_addr <= i_addr;
        if (!IS_READ) r_data <= i_wdata;
      end else if ((r_state == REQ || r_state == WAIT) && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_done_ok) begin
        r_resp <= RESP_OKAY;
        if (IS_READ) r_data <= i_rdata;
      end else if (w_done_err) begin
        r_resp <= RESP_SLVERR;
        if (IS_READ) r_data <= TIMEOUT_RDATA;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_resp = r_resp;

endmodule

// File: rtl/up_axil_initiator.sv
// AXI4-Lite slave to up_* register-bus initiator: independent write and read engines.
module up_axil_initiator
  import up_axil_pkg::*;
#(
  parameter int          ADDRESS_WIDTH  = 14,
  parameter int          TIMEOUT_CYCLES = 31,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
  input  logic         up_clk,
  input  logic         up_rstn,
  up_axil_initiator_if.slave s_bus
);

  logic w_wr_ready;
  logic w_wr_start;
  logic w_unused;

  // aw and w are only taken together, so a lone address or data beat waits
  assign w_wr_start = s_bus.s_axi_awvalid & s_bus.s_axi_wvalid;
  assign s_bus.s_axi_awready = w_wr_ready;
  assign s_bus.s_axi_wready  = w_wr_ready;
  assign w_unused = ^{s_bus.s_axi_awaddr[1:0], s_bus.s_axi_araddr[1:0], s_bus.s_axi_wstrb};

  up_axil_txn_fsm #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_RDATA  (TIMEOUT_RDATA),
    .IS_READ        (1'b0)
  ) u_wr (
    .up_clk       (up_clk),
    .up_rstn      (up_rstn),
    .i_start      (w_wr_start),
    .i_addr       (s_bus.s_axi_awaddr[ADDRESS_WIDTH+1:2]),
    .i_wdata      (s_bus.s_axi_wdata),
    .i_ack        (s_bus.up_wack),
    .i_rdata      (32'h0),
    .i_resp_ready (s_bus.s_axi_bready),
    .o_ready      (w_wr_ready),
    .o_req        (s_bus.up_wreq),
    .o_addr       (s_bus.up_waddr),
    .o_data       (s_bus.up_wdata),
    .o_valid      (s_bus.s_axi_bvalid),
    .o_resp       (s_bus.s_axi_bresp)
  );

  up_axil_txn_fsm #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_RDATA  (TIMEOUT_RDATA),
    .IS_READ        (1'b1)
  ) u_rd (
    .up_clk       (up_clk),
    .up_rstn      (up_rstn),
    .i_start      (s_bus.s_axi_arvalid),
    .i_addr       (s_bus.s_axi_araddr[ADDRESS_WIDTH+1:2]),
    .i_wdata      (32'h0),
    .i_ack        (s_bus.up_rack),
    .i_rdata      (s_bus.up_rdata),
    .i_resp_ready (s_bus.s_axi_rready),
    .o_ready      (s_bus.s_axi_arready),
    .o_req        (s_bus.up_rreq),
    .o_addr       (s_bus.up_raddr),
    .o_data       (s_bus.s_axi_rdata),
    .o_valid      (s_bus.s_axi_rvalid),
    .o_resp       (s_bus.s_axi_rresp)
  );

endmodule

// File: tb/tb_up_axil_initiator.sv
// Bench for up_axil_initiator: register-bank responder plus directed and random AXI transactions.
module tb_up_axil_initiator;

  localparam int          AW      = 14;
  localparam int          TO      = 31;
  localparam logic [31:0] TO_DATA = 32'hDEAD_DEAD;

  logic up_clk  = 1'b0;
  logic up_rstn = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  up_axil_initiator_if #(.ADDRESS_WIDTH(AW)) bus();

  up_axil_initiator #(
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_RDATA  (TO_DATA)
  ) dut (
    .up_clk  (up_clk),
    .up_rstn (up_rstn),
    .s_bus   (bus.slave)
  );

  always #5 up_clk = ~up_clk;

  // register-bank responder: ack N cycles after the strobe (N = -1 never), counts strobes and responses
  int          w_ack_dly = -1, r_ack_dly = -1, w_cd = -1, r_cd = -1;
  logic [31:0] r_ack_data = '0;
  int          wreq_cnt = 0, rreq_cnt = 0, bresp_cnt = 0, rresp_cnt = 0;
  int          cyc_g = 0, wreq_cyc = 0, rreq_cyc = 0;
  bit          bv_q = 1'b0, rv_q = 1'b0, stray = 1'b0;

  always @(negedge up_clk) begin
    cyc_g++;
    bus.up_wack  = 1'b0;
    bus.up_rack  = 1'b0;
    bus.up_rdata = $urandom;
    if (bus.up_wreq === 1'b1) begin wreq_cnt++; wreq_cyc = cyc_g; w_cd = w_ack_dly; end
    if (bus.up_rreq === 1'b1) begin rreq_cnt++; rreq_cyc = cyc_g; r_cd = r_ack_dly; end
    if (w_cd == 0) bus.up_wack = 1'b1;
    if (w_cd >= 0) w_cd--;
    if (r_cd == 0) begin bus.up_rack = 1'b1; bus.up_rdata = r_ack_data; end
    if (r_cd >= 0) r_cd--;
    if (stray) begin bus.up_wack = 1'b1; bus.up_rack = 1'b1; stray = 1'b0; end
    if (bus.s_axi_bvalid === 1'b1 && !bv_q) bresp_cnt++;
    if (bus.s_axi_rvalid === 1'b1 && !rv_q) rresp_cnt++;
    bv_q = (bus.s_axi_bvalid === 1'b1);
    rv_q = (bus.s_axi_rvalid === 1'b1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {25'd0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_bresp,
            bus.s_axi_arready, bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata,
            bus.up_wreq, bus.up_waddr, bus.up_wdata, bus.up_rreq, bus.up_raddr};
  endfunction

  // One write and/or read started in the same cycle; expectations come from the ack delay alone.
  task automatic run_txn(input bit do_w, input bit do_r,
                         input logic [15:0] aw, input logic [31:0] wd, input int wdly,
                         input logic [15:0] ar, input logic [31:0] rd, input int rdly,
                         input int hold);
    bit          w_ok, r_ok;
    int          w_lat, r_lat, w_rel, r_rel, wq0, rq0, bc0, rc0;
    logic [1:0]  w_resp, r_resp;
    logic [31:0] r_exp;
    bit          w_acc = 0, w_got = 0, w_done, r_acc = 0, r_got = 0, r_done;
    w_ok   = (wdly >= 0 && wdly <= TO);
    r_ok   = (rdly >= 0 && rdly <= TO);
    w_lat  = w_ok ? 3 + wdly : 3 + TO;
    r_lat  = r_ok ? 3 + rdly : 3 + TO;
    w_resp = w_ok ? 2'b00 : 2'b10;
    r_resp = r_ok ? 2'b00 : 2'b10;
    r_exp  = r_ok ? rd : TO_DATA;
    wq0 = wreq_cnt; rq0 = rreq_cnt; bc0 = bresp_cnt; rc0 = rresp_cnt;
    w_ack_dly = wdly; r_ack_dly = rdly; r_ack_data = rd;
    w_done = !do_w; r_done = !do_r;
    if (do_w) begin
      bus.s_axi_awaddr = aw; bus.s_axi_wdata = wd; bus.s_axi_wstrb = 4'($urandom);
      bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    end
    if (do_r) begin bus.s_axi_araddr = ar; bus.s_axi_arvalid = 1'b1; end
    for (int c = 1; c <= 400 && !(w_done && r_done); c++) begin
      @(negedge up_clk);
      if (!w_done) begin
        if (c == 2) check("up_wreq_cycle", bus.up_wreq, 1'b1);
        if (!w_acc && bus.s_axi_awready === 1'b1) begin
          w_acc = 1;
          check("aw_accept_cycle", c, 1);
          check("wready_with_awready", bus.s_axi_wready, 1'b1);
          bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        end
        if (!w_got && bus.s_axi_bvalid === 1'b1) begin
          w_got = 1; w_rel = c + hold;
          check("b_latency", c, w_lat);
          check("bresp", bus.s_axi_bresp, w_resp);
          check("up_waddr", bus.up_waddr, aw[15:2]);
          check("up_wdata", bus.up_wdata, wd);
        end else if (w_got && c <= w_rel) begin
          check("bvalid_held", bus.s_axi_bvalid, 1'b1);
          check("bresp_held", bus.s_axi_bresp, w_resp);
        end else if (w_got) begin
          check("bvalid_drop", bus.s_axi_bvalid, 1'b0);
          bus.s_axi_bready = 1'b0; w_done = 1;
        end
        if (w_got && !w_done && c == w_rel) bus.s_axi_bready = 1'b1;
      end
      if (!r_done) begin
        if (c == 2) check("up_rreq_cycle", bus.up_rreq, 1'b1);
        if (!r_acc && bus.s_axi_arready === 1'b1) begin
          r_acc = 1;
          check("ar_accept_cycle", c, 1);
          bus.s_axi_arvalid = 1'b0;
        end
        if (!r_got && bus.s_axi_rvalid === 1'b1) begin
          r_got = 1; r_rel = c + hold;
          check("r_latency", c, r_lat);
          check("rresp", bus.s_axi_rresp, r_resp);
          check("rdata", bus.s_axi_rdata, r_exp);
          check("up_raddr", bus.up_raddr, ar[15:2]);
        end else if (r_got && c <= r_rel) begin
          check("rvalid_held", bus.s_axi_rvalid, 1'b1);
          check("rdata_held", {bus.s_axi_rresp, bus.s_axi_rdata}, {r_resp, r_exp});
        end else if (r_got) begin
          check("rvalid_drop", bus.s_axi_rvalid, 1'b0);
          bus.s_axi_rready = 1'b0; r_done = 1;
        end
        if (r_got && !r_done && c == r_rel) bus.s_axi_rready = 1'b1;
      end
    end
    check("w_complete", w_done, 1'b1);
    check("r_complete", r_done, 1'b1);
    check("aw_accepted", w_acc, do_w);
    check("ar_accepted", r_acc, do_r);
    repeat (12) @(negedge up_clk);
    check("wreq_pulses", wreq_cnt - wq0, int'(do_w));
    check("rreq_pulses", rreq_cnt - rq0, int'(do_r));
    check("b_responses", bresp_cnt - bc0, int'(do_w));
    check("r_responses", rresp_cnt - rc0, int'(do_r));
  endtask

  initial begin
    int wq0, bc0, rc0, rq0;
    bus.s_axi_awvalid = 0; bus.s_axi_awaddr = '0; bus.s_axi_wvalid = 0; bus.s_axi_wdata = '0;
    bus.s_axi_wstrb = '0; bus.s_axi_bready = 0; bus.s_axi_arvalid = 0; bus.s_axi_araddr = '0;
    bus.s_axi_rready = 0; bus.up_wack = 0; bus.up_rack = 0; bus.up_rdata = '0;

    repeat (3) @(negedge up_clk);
    check("reset_outputs", outs(), '0);
    up_rstn = 1'b1;
    @(negedge up_clk);

    run_txn(1, 0, 16'h0104, 32'h1234_5678, 1, 16'h0, 32'h0, -1, 0);
    run_txn(0, 1, 16'h0, 32'h0, -1, 16'h0008, 32'hCAFE_F00D, 2, 0);
    run_txn(1, 1, 16'h0200, 32'h55AA_55AA, TO + 4, 16'h0300, 32'h0BAD_0001, TO + 3, 1);
    run_txn(1, 1, 16'h3FFC, 32'hA5A5_0000, TO, 16'hFFFF, 32'h1357_9BDF, 0, 2);
    run_txn(1, 1, 16'h0010, 32'h0000_0001, 0, 16'h0014, 32'h8000_0000, TO, 0);

    bc0 = bresp_cnt; rc0 = rresp_cnt;
    stray = 1'b1;
    repeat (6) @(negedge up_clk);
    check("stray_no_bresp", bresp_cnt - bc0, 0);
    check("stray_no_rresp", rresp_cnt - rc0, 0);

    wq0 = wreq_cnt;
    bus.s_axi_awaddr = 16'h0444; bus.s_axi_awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge up_clk);
      check("lone_aw_no_ready", bus.s_axi_awready, 1'b0);
    end
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge up_clk);
      check("lone_w_no_ready", bus.s_axi_wready, 1'b0);
    end
    check("lone_no_wreq", wreq_cnt - wq0, 0);
    bus.s_axi_awvalid = 1'b1;
    run_txn(1, 0, 16'h0444, 32'h0F0F_1234, 3, 16'h0, 32'h0, -1, 0);

    run_txn(1, 1, 16'h0120, 32'h0BEE_F00D, 2, 16'h0124, 32'h7777_8888, 3, 5);
    check("same_cycle_strobes", wreq_cyc, rreq_cyc);

    w_ack_dly = -1; r_ack_dly = -1;
    bus.s_axi_awaddr = 16'h0050; bus.s_axi_wdata = 32'h1111_2222; bus.s_axi_araddr = 16'h0060;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    @(negedge up_clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    repeat (4) @(negedge up_clk);
    #2 up_rstn = 1'b0;
    #1 check("reset_mid_wait", outs(), '0);
    wq0 = wreq_cnt; rq0 = rreq_cnt; bc0 = bresp_cnt; rc0 = rresp_cnt;
    repeat (2) @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (40) @(negedge up_clk);
    check("post_reset_no_bresp", bresp_cnt - bc0, 0);
    check("post_reset_no_rresp", rresp_cnt - rc0, 0);
    check("post_reset_no_req", (wreq_cnt - wq0) + (rreq_cnt - rq0), 0);
    run_txn(1, 1, 16'h0070, 32'h3333_4444, 1, 16'h0074, 32'h5555_6666, 1, 1);

    for (int i = 0; i < 10; i++) begin
      bit dw, dr;
      int wd_l, rd_l;
      dw = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!dw && !dr) dw = 1'b1;
      wd_l = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 5));
      rd_l = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 5));
      run_txn(dw, dr, 16'($urandom), $urandom, wd_l, 16'($urandom), $urandom, rd_l,
              int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
